// File: rtl/ps2_port.sv
// ============================================================================
// ps2_port
//
// Host-side PS/2 port controller. It receives 11-bit device frames as bytes
// and sends host-to-device command bytes using the inhibit / request-to-send
// sequence. Filtering, inhibit time and timeouts are all counted in ck1us
// ticks, so the clk6x frequency does not affect protocol timing.
//
// Ports:
//   clk6x        system clock
//   resetn       synchronous, active-low reset
//   ck1us        one-cycle strobe every microsecond
//   ps2_clk_i    raw PS/2 clock pin (asynchronous)
//   ps2_data_i   raw PS/2 data pin (asynchronous)
//   ps2_clk_oe   1 = pull the clock pin low
//   ps2_data_oe  1 = pull the data pin low
//   rx_data      last good received byte
//   rx_valid     one-cycle pulse, rx_data just updated
//   rx_err       one-cycle pulse, bad frame or receive timeout
//   tx_data      byte to send, captured when tx_start is accepted
//   tx_start     transmit request, ignored while tx_busy
//   tx_busy      controller is not idle
//   tx_ack       one-cycle pulse, device acknowledged the byte
//   tx_err       one-cycle pulse, no acknowledge or transmit timeout
// ============================================================================
module ps2_port #(
    parameter int FILTER_US  = 4,
    parameter int TIMEOUT_US = 200,
    parameter int INHIBIT_US = 100,
    parameter int TX_WAIT_US = 15000
) (
    input  logic       clk6x,
    input  logic       resetn,
    input  logic       ck1us,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_ack,
    output logic       tx_err
);

    typedef enum logic [1:0] {
        IDLE,
        RX,
        TX_INHIBIT,
        TX_BITS
    } state_t;

    localparam int          FCW          = $clog2(FILTER_US + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_US - 1);
    localparam logic [15:0] TIMEOUT_LIM  = 16'(TIMEOUT_US);
    localparam logic [15:0] INHIBIT_LIM  = 16'(INHIBIT_US);
    localparam logic [15:0] TX_WAIT_LIM  = 16'(TX_WAIT_US);

    state_t           state_q, state_d;
    logic [1:0]       clkSync_q, dataSync_q;
    logic [FCW-1:0]   filtCnt_q;
    logic             filtClk_q, filtPrev_q;
    logic [15:0]      timer_q;
    logic [3:0]       bitCnt_q;
    logic [9:0]       rxShift_q;
    logic [7:0]       rxData_q;
    logic [7:0]       txByte_q;
    logic             txPar_q;
    logic             dataOe_q;
    logic             rxValid_q, rxErr_q, txAck_q, txErr_q;

    logic             clkS, dataS, fall;
    logic [10:0]      rxFrame;
    logic             frameOk;
    logic [15:0]      txLimit;
    logic             rxStart, txAccept, rxDone, rxTimeout;
    logic             inhibitDone, txDone, txTimeout;

    // Two-flop synchronizers; idle-high so reset looks like a released bus.
    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk_i};
            dataSync_q <= {dataSync_q[0], ps2_data_i};
        end
    end

    assign clkS  = clkSync_q[1];
    assign dataS = dataSync_q[1];

    // Clock glitch filter: the filtered clock follows the synced clock only
    // after FILTER_US consecutive microsecond ticks of disagreement. Any
    // cycle of agreement restarts the count.
    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            filtClk_q  <= 1'b1;
            filtPrev_q <= 1'b1;
            filtCnt_q  <= '0;
        end else begin
            filtPrev_q <= filtClk_q;
            if (clkS == filtClk_q) begin
                filtCnt_q <= '0;
            end else if (ck1us) begin
                if (filtCnt_q == FILT_LAST) begin
                    filtClk_q <= clkS;
                    filtCnt_q <= '0;
                end else begin
                    filtCnt_q <= filtCnt_q + 1'b1;
                end
            end
        end
    end

    assign fall = filtPrev_q & ~filtClk_q;

    // Complete frame as it would look with the current data bit as the stop.
    assign rxFrame = {dataS, rxShift_q};
    assign frameOk = ~rxFrame[0] & (^rxFrame[9:1]) & rxFrame[10];

    // Before the device's first edge it may take much longer to respond.
    assign txLimit = (bitCnt_q == 4'd0) ? TX_WAIT_LIM : TIMEOUT_LIM;

    // Shared decision terms; a fall always takes priority over a timeout.
    assign rxStart     = (state_q == IDLE) && fall;
    assign txAccept    = (state_q == IDLE) && !fall && tx_start;
    assign rxDone      = (state_q == RX) && fall && (bitCnt_q == 4'd10);
    assign rxTimeout   = (state_q == RX) && !fall && (timer_q >= TIMEOUT_LIM);
    assign inhibitDone = (state_q == TX_INHIBIT) && (timer_q >= INHIBIT_LIM);
    assign txDone      = (state_q == TX_BITS) && fall && (bitCnt_q == 4'd10);
    assign txTimeout   = (state_q == TX_BITS) && !fall && (timer_q >= txLimit);

    // State register.
    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rxStart) begin
                    state_d = RX;
                end else if (txAccept) begin
                    state_d = TX_INHIBIT;
                end
            end
            RX: begin
                if (rxDone || rxTimeout) begin
                    state_d = IDLE;
                end
            end
            TX_INHIBIT: begin
                if (inhibitDone) begin
                    state_d = TX_BITS;
                end
            end
            TX_BITS: begin
                if (txDone || txTimeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: timer, bit counter, shift registers, line drive and pulses.
    // The timer is cleared by falls only where falls are protocol edges; in
    // TX_INHIBIT the host's own clock pull produces a fall that must not
    // stretch the inhibit time.
    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            timer_q   <= '0;
            bitCnt_q  <= '0;
            rxShift_q <= '0;
            rxData_q  <= '0;
            txByte_q  <= '0;
            txPar_q   <= 1'b0;
            dataOe_q  <= 1'b0;
            rxValid_q <= 1'b0;
            rxErr_q   <= 1'b0;
            txAck_q   <= 1'b0;
            txErr_q   <= 1'b0;
        end else begin
            rxValid_q <= 1'b0;
            rxErr_q   <= 1'b0;
            txAck_q   <= 1'b0;
            txErr_q   <= 1'b0;

            if ((state_d != state_q) ||
                (fall && ((state_q == RX) || (state_q == TX_BITS)))) begin
                timer_q <= '0;
            end else if (ck1us && (timer_q != 16'hFFFF)) begin
                timer_q <= timer_q + 16'd1;
            end

            if (rxStart) begin
                rxShift_q <= {dataS, rxShift_q[9:1]};
                bitCnt_q  <= 4'd1;
            end else if (txAccept) begin
                txByte_q <= tx_data;
                txPar_q  <= ~^tx_data;
                bitCnt_q <= 4'd0;
            end

            if ((state_q == RX) && fall) begin
                rxShift_q <= {dataS, rxShift_q[9:1]};
                bitCnt_q  <= bitCnt_q + 4'd1;
            end
            if (rxDone) begin
                bitCnt_q <= 4'd0;
                if (frameOk) begin
                    rxData_q  <= rxFrame[8:1];
                    rxValid_q <= 1'b1;
                end else begin
                    rxErr_q <= 1'b1;
                end
            end
            if (rxTimeout) begin
                bitCnt_q <= 4'd0;
                rxErr_q  <= 1'b1;
            end

            // End of inhibit: pull data low as the start bit.
            if (inhibitDone) begin
                dataOe_q <= 1'b1;
            end

            // Each device fall presents the next bit: data, parity, stop.
            if ((state_q == TX_BITS) && fall) begin
                bitCnt_q <= bitCnt_q + 4'd1;
                if (bitCnt_q < 4'd8) begin
                    dataOe_q <= ~txByte_q[bitCnt_q[2:0]];
                end else if (bitCnt_q == 4'd8) begin
                    dataOe_q <= ~txPar_q;
                end else begin
                    dataOe_q <= 1'b0;
                end
            end
            if (txDone) begin
                bitCnt_q <= 4'd0;
                if (dataS) begin
                    txErr_q <= 1'b1;
                end else begin
                    txAck_q <= 1'b1;
                end
            end
            if (txTimeout) begin
                bitCnt_q <= 4'd0;
                dataOe_q <= 1'b0;
                txErr_q  <= 1'b1;
            end
        end
    end

    // State-decoded outputs.
    always_comb begin
        ps2_clk_oe = (state_q == TX_INHIBIT);
        tx_busy    = (state_q != IDLE);
    end

    assign ps2_data_oe = dataOe_q;
    assign rx_data     = rxData_q;
    assign rx_valid    = rxValid_q;
    assign rx_err      = rxErr_q;
    assign tx_ack      = txAck_q;
    assign tx_err      = txErr_q;

endmodule

// File: tb/tb_ps2_port.sv
// ============================================================================
// tb_ps2_port
//
// Directed bench for ps2_port. A device model drives the open-collector
// clock and data lines (wired-AND with the host's output enables), and
// pulse monitors count rx_valid / rx_err / tx_ack / tx_err. ck1us pulses
// every 4 clk6x cycles so one microsecond is 4 clocks.
// ============================================================================
module tb_ps2_port;

    logic       clk6x = 1'b0;
    logic       resetn = 1'b0;
    logic       ck1us = 1'b0;
    logic       devClk = 1'b1;
    logic       devData = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;

    logic       ps2ClkPin, ps2DataPin;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_err, tx_busy, tx_ack, tx_err;

    int checkCnt = 0;
    int passCnt = 0;
    int rxValidCnt = 0;
    int rxErrCnt = 0;
    int txAckCnt = 0;
    int txErrCnt = 0;
    int overlapCnt = 0;
    int divCnt = 0;

    // Open-collector bus: either side pulling low wins.
    assign ps2ClkPin  = devClk & ~ps2_clk_oe;
    assign ps2DataPin = devData & ~ps2_data_oe;

    ps2_port dut (
        .clk6x      (clk6x),
        .resetn     (resetn),
        .ck1us      (ck1us),
        .ps2_clk_i  (ps2ClkPin),
        .ps2_data_i (ps2DataPin),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_err     (rx_err),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_ack     (tx_ack),
        .tx_err     (tx_err)
    );

    always #5 clk6x = ~clk6x;

    // Microsecond strobe, changed on the falling edge so it is stable at
    // the rising edge where the DUT samples it.
    initial begin
        forever begin
            @(negedge clk6x);
            ck1us = (divCnt == 3);
            divCnt = (divCnt == 3) ? 0 : divCnt + 1;
        end
    end

    // Pulse monitors; also flag any completion pulse seen while still busy.
    always @(negedge clk6x) begin
        if (rx_valid === 1'b1) rxValidCnt++;
        if (rx_err === 1'b1) rxErrCnt++;
        if (tx_ack === 1'b1) txAckCnt++;
        if (tx_err === 1'b1) txErrCnt++;
        if (((tx_ack === 1'b1) || (tx_err === 1'b1)) && (tx_busy === 1'b1)) overlapCnt++;
    end

    task automatic waitUs(input int n);
        repeat (4 * n) @(negedge clk6x);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCnt++;
        assert (observed === expected) passCnt++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic checkRange(input string tag, input int observed, input int lo, input int hi);
        checkCnt++;
        assert ((observed >= lo) && (observed <= hi)) passCnt++;
        else $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
    endtask

    // Frame layout on the wire, bit 0 first: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] mkFrame(input logic [7:0] d, input logic parFlip);
        return {1'b1, (~^d) ^ parFlip, d, 1'b0};
    endfunction

    // Device sends the first nbits of a frame at an 80 us clock period.
    task automatic applyStimulus(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            devData = frame[i];
            waitUs(20);
            devClk = 1'b0;
            waitUs(40);
            devClk = 1'b1;
            waitUs(20);
        end
        devData = 1'b1;
    endtask

    // One complete host-to-device transfer with the device model clocking.
    task automatic runTransmit(input logic [7:0] d, input logic ack, input string name);
        int n;
        int a0;
        int e0;
        logic [9:0] seen;
        a0 = txAckCnt;
        e0 = txErrCnt;
        seen = '0;
        tx_data = d;
        tx_start = 1'b1;
        @(negedge clk6x);
        tx_start = 1'b0;
        checkOutput({name, "_busy_rise"}, {31'd0, tx_busy}, 32'd1);
        checkOutput({name, "_inhibit_clk"}, {31'd0, ps2_clk_oe}, 32'd1);
        n = 1;
        while ((ps2_clk_oe === 1'b1) && (n < 1000)) begin
            @(negedge clk6x);
            n++;
        end
        checkRange({name, "_inhibit_cycles"}, n, 396, 404);
        checkOutput({name, "_start_bit"}, {31'd0, ps2_data_oe}, 32'd1);
        waitUs(20);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) devData = ~ack;
            devClk = 1'b0;
            waitUs(40);
            if (k <= 10) seen[k-1] = ps2DataPin;
            devClk = 1'b1;
            waitUs(40);
        end
        devData = 1'b1;
        waitUs(10);
        checkOutput({name, "_line_bits"}, {22'd0, seen}, {22'd0, 1'b1, ~^d, d});
        checkOutput({name, "_ack_pulses"}, txAckCnt - a0, ack ? 32'd1 : 32'd0);
        checkOutput({name, "_err_pulses"}, txErrCnt - e0, ack ? 32'd0 : 32'd1);
        checkOutput({name, "_idle_lines"}, {29'd0, tx_busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
    endtask

    initial begin
        int n;
        int v0;
        int e0;
        int a0;
        logic [10:0] frame;

        // Reset with the strobe running.
        resetn = 1'b0;
        repeat (10) @(negedge clk6x);
        checkOutput("reset_outputs",
                    {17'd0, rx_data, rx_valid, rx_err, tx_busy, tx_ack, tx_err,
                     ps2_clk_oe, ps2_data_oe}, 32'd0);
        resetn = 1'b1;
        waitUs(10);
        checkOutput("post_reset_idle", {30'd0, tx_busy, ps2_clk_oe}, 32'd0);

        // Good receive of 0x1C.
        v0 = rxValidCnt;
        e0 = rxErrCnt;
        applyStimulus(mkFrame(8'h1C, 1'b0), 11);
        waitUs(20);
        checkOutput("rx1c_valid", rxValidCnt - v0, 32'd1);
        checkOutput("rx1c_err", rxErrCnt - e0, 32'd0);
        checkOutput("rx1c_data", {24'd0, rx_data}, 32'h1C);

        // Same frame with the parity bit flipped.
        v0 = rxValidCnt;
        e0 = rxErrCnt;
        applyStimulus(mkFrame(8'h1C, 1'b1), 11);
        waitUs(20);
        checkOutput("rxpar_err", rxErrCnt - e0, 32'd1);
        checkOutput("rxpar_valid", rxValidCnt - v0, 32'd0);
        checkOutput("rxpar_data_kept", {24'd0, rx_data}, 32'h1C);

        // 2 us glitch must not start a frame (a false start would time out).
        v0 = rxValidCnt;
        e0 = rxErrCnt;
        devClk = 1'b0;
        waitUs(2);
        devClk = 1'b1;
        waitUs(250);
        checkOutput("glitch_no_err", rxErrCnt - e0, 32'd0);
        checkOutput("glitch_idle", {31'd0, tx_busy}, 32'd0);
        applyStimulus(mkFrame(8'h1C, 1'b0), 11);
        waitUs(20);
        checkOutput("glitch_rx_valid", rxValidCnt - v0, 32'd1);
        checkOutput("glitch_rx_data", {24'd0, rx_data}, 32'h1C);

        // Receive timeout: five edges then silence.
        v0 = rxValidCnt;
        e0 = rxErrCnt;
        frame = mkFrame(8'h55, 1'b0);
        applyStimulus(frame, 4);
        devData = frame[4];
        waitUs(20);
        devClk = 1'b0;
        n = 0;
        while ((rx_err !== 1'b1) && (n < 2000)) begin
            @(negedge clk6x);
            n++;
            if (n == 160) devClk = 1'b1;
        end
        devClk = 1'b1;
        devData = 1'b1;
        checkRange("rx_timeout_cycles", n, 800, 832);
        waitUs(20);
        checkOutput("rx_timeout_err", rxErrCnt - e0, 32'd1);
        checkOutput("rx_timeout_valid", rxValidCnt - v0, 32'd0);
        v0 = rxValidCnt;
        applyStimulus(mkFrame(8'hAA, 1'b0), 11);
        waitUs(20);
        checkOutput("rxaa_valid", rxValidCnt - v0, 32'd1);
        checkOutput("rxaa_data", {24'd0, rx_data}, 32'hAA);

        // Transmit with device acknowledge, then without.
        runTransmit(8'hFF, 1'b1, "txff");
        waitUs(20);
        runTransmit(8'h5A, 1'b0, "tx5a");
        waitUs(20);

        // Reset while the host pulls data low for the start bit.
        a0 = txAckCnt;
        e0 = txErrCnt;
        tx_data = 8'h12;
        tx_start = 1'b1;
        @(negedge clk6x);
        tx_start = 1'b0;
        n = 0;
        while ((ps2_clk_oe === 1'b1) && (n < 1000)) begin
            @(negedge clk6x);
            n++;
        end
        waitUs(5);
        checkOutput("midtx_data_low", {31'd0, ps2_data_oe}, 32'd1);
        resetn = 1'b0;
        @(negedge clk6x);
        checkOutput("midtx_reset_release", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        resetn = 1'b1;
        waitUs(50);
        checkOutput("midtx_no_pulses", (txAckCnt - a0) + (txErrCnt - e0), 32'd0);
        checkOutput("midtx_idle", {31'd0, tx_busy}, 32'd0);
        checkOutput("done_busy_overlap", overlapCnt, 32'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
